// File: rtl/turf_tally_if.sv
// turf_tally_if: bundles the tally request, the playfield RAM read port and
// the published results of the turf_tally scorer.
//
// Signals:
//   start           - single-cycle tally request
//   player_colours  - colour of player i at [i*COLOUR_W +: COLOUR_W]
//   ram_address     - read address to the playfield RAM
//   ram_data        - pixel returned RAM_LATENCY cycles after its address
//   counts          - pixel count of player i at slot i
//   rank_idx        - player indices in rank order, slot 0 is the leader
//   ordered_colours - player colours in rank order, slot 0 is the leader
//   leader_tie      - rank-0 and rank-1 counts are equal
//   busy            - tally in progress
//   done_ordering   - results valid, held until the next start or reset
//
// Modports: master is the game/RAM side, slave is the scorer.
interface turf_tally_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int COLOUR_W    = 3,
  parameter int ADDR_W      = 15,
  parameter int CNT_W       = 15,
  parameter int IDX_W       = 3
);
  logic                            start;
  logic [NUM_PLAYERS*COLOUR_W-1:0] player_colours;
  logic [ADDR_W-1:0]               ram_address;
  logic [COLOUR_W-1:0]             ram_data;
  logic [NUM_PLAYERS*CNT_W-1:0]    counts;
  logic [NUM_PLAYERS*IDX_W-1:0]    rank_idx;
  logic [NUM_PLAYERS*COLOUR_W-1:0] ordered_colours;
  logic                            leader_tie;
  logic                            busy;
  logic                            done_ordering;

  modport master (
    output start, player_colours, ram_data,
    input  ram_address, counts, rank_idx, ordered_colours,
           leader_tie, busy, done_ordering
  );

  modport slave (
    input  start, player_colours, ram_data,
    output ram_address, counts, rank_idx, ordered_colours,
           leader_tie, busy, done_ordering
  );
endinterface

// File: rtl/turf_tally.sv
// turf_tally: end-of-round territory scorer.
// Sweeps the playfield colour RAM once per start, counts the pixels owned by
// each player, ranks the players with a sequential odd-even transposition
// sort and publishes counts, ranked indices and ranked colours.
//
// Ports:
//   clock25 - block clock, rising edge
//   reset   - asynchronous, active-high; returns the block to IDLE
//   bus     - turf_tally_if.slave (start, colours, RAM port, results)
module turf_tally #(
  parameter int                NUM_PLAYERS = 4,
  parameter int                COLOUR_W    = 3,
  parameter int                ADDR_W      = 15,
  parameter logic [ADDR_W-1:0] LAST_ADDR   = 15'h4F7F,
  parameter int                CNT_W       = 15,
  parameter int                RAM_LATENCY = 1,
  parameter int                IDX_W       = 3
) (
  input logic         clock25,
  input logic         reset,
  turf_tally_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SORT, DONE} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    addr;
  logic [RAM_LATENCY-1:0] vpipe;
  logic [1:0]           drain_cnt;
  logic [IDX_W-1:0]     sort_cnt;
  logic [CNT_W-1:0]     cnt       [NUM_PLAYERS];
  logic [IDX_W-1:0]     order     [NUM_PLAYERS];
  logic [IDX_W-1:0]     order_nxt [NUM_PLAYERS];
  logic [IDX_W-1:0]     rank_r    [NUM_PLAYERS];
  logic [COLOUR_W-1:0]  ocol_r    [NUM_PLAYERS];
  logic [COLOUR_W-1:0]  pcol      [NUM_PLAYERS];
  logic                 tie_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;

  // Unpack the player colours and find the lowest-indexed player whose colour
  // matches the returned pixel; scanning downwards lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      pcol[i] = bus.player_colours[i*COLOUR_W +: COLOUR_W];
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (bus.player_colours[i*COLOUR_W +: COLOUR_W] == bus.ram_data) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // One odd-even transposition pass over the working order. The pass parity
  // follows the sort cycle; pairs are disjoint so they can all swap at once.
  // Only a strictly larger right-hand count swaps, which keeps ties stable.
  always_comb begin
    for (int j = 0; j < NUM_PLAYERS; j++)
      order_nxt[j] = order[j];
    for (int j = 0; j < NUM_PLAYERS - 1; j++) begin
      if ((j % 2) == int'(sort_cnt[0])) begin
        if (cnt[order[j+1]] > cnt[order[j]]) begin
          order_nxt[j]   = order[j+1];
          order_nxt[j+1] = order[j];
        end
      end
    end
  end

  // Main sequencer: scan, drain the RAM pipeline, sort, publish.
  // The valid delay line tags each issued address so that the sample arriving
  // RAM_LATENCY cycles later is counted exactly once.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      vpipe     <= '0;
      drain_cnt <= '0;
      sort_cnt  <= '0;
      tie_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        cnt[i]    <= '0;
        order[i]  <= IDX_W'(i);
        rank_r[i] <= IDX_W'(i);
        ocol_r[i] <= '0;
      end
    end else begin
      vpipe[0] <= (state == SCAN);
      for (int i = 1; i < RAM_LATENCY; i++)
        vpipe[i] <= vpipe[i-1];

      if (vpipe[RAM_LATENCY-1] && hit && (cnt[hit_idx] != '1))
        cnt[hit_idx] <= cnt[hit_idx] + CNT_W'(1);

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            addr     <= '0;
            sort_cnt <= '0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            state    <= SCAN;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              cnt[i]   <= '0;
              order[i] <= IDX_W'(i);
            end
          end
        end
        SCAN: begin
          if (addr == LAST_ADDR) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(RAM_LATENCY - 1))
            state <= SORT;
          else
            drain_cnt <= drain_cnt + 2'd1;
        end
        SORT: begin
          sort_cnt <= sort_cnt + IDX_W'(1);
          for (int i = 0; i < NUM_PLAYERS; i++)
            order[i] <= order_nxt[i];
          if (sort_cnt == IDX_W'(NUM_PLAYERS - 1)) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              rank_r[i] <= order_nxt[i];
              ocol_r[i] <= pcol[order_nxt[i]];
            end
            tie_r  <= (cnt[order_nxt[0]] == cnt[order_nxt[1]]);
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flatten the per-player registers onto the packed result buses.
  always_comb begin
    bus.counts          = '0;
    bus.rank_idx        = '0;
    bus.ordered_colours = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.counts[i*CNT_W +: CNT_W]                = cnt[i];
      bus.rank_idx[i*IDX_W +: IDX_W]              = rank_r[i];
      bus.ordered_colours[i*COLOUR_W +: COLOUR_W] = ocol_r[i];
    end
  end

  assign bus.ram_address   = addr;
  assign bus.leader_tie    = tie_r;
  assign bus.busy          = busy_r;
  assign bus.done_ordering = done_r;

endmodule

// File: tb/tb_turf_tally.sv
// tb_turf_tally: self-checking bench for turf_tally.
// Three instances: A (defaults), B (6 players, RAM latency 3) and
// C (4 players, RAM latency 2, 1024-pixel field, 9-bit counters).
module tb_turf_tally;

  typedef struct {
    string name;
    int    colours  [4];
    int    px       [8];
    int    exp_cnt  [4];
    int    exp_rank [4];
    int    exp_col  [4];
    int    exp_tie;
  } vec_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int np_of   [3] = '{4, 6, 4};
  int lat_of  [3] = '{1, 3, 2};
  int last_of [3] = '{20351, 20351, 1023};
  int sat_of  [3] = '{32767, 32767, 511};

  logic       start_s [3];
  logic       rst_s   [3];
  int         pcol    [3][8];
  logic [2:0] mem     [3][20352];
  logic [2:0] rp      [3][3];

  int obs_cnt  [3][8];
  int obs_rank [3][8];
  int obs_col  [3][8];
  int obs_tie  [3];
  int obs_done [3];
  int obs_busy [3];
  int obs_addr [3];

  int n_checks = 0;
  int n_fail   = 0;

  turf_tally_if #(.NUM_PLAYERS(4))             bus_a ();
  turf_tally_if #(.NUM_PLAYERS(6))             bus_b ();
  turf_tally_if #(.NUM_PLAYERS(4), .CNT_W(9))  bus_c ();

  turf_tally #(.NUM_PLAYERS(4)) dut_a (
    .clock25(clk), .reset(rst_s[0]), .bus(bus_a.slave));
  turf_tally #(.NUM_PLAYERS(6), .RAM_LATENCY(3)) dut_b (
    .clock25(clk), .reset(rst_s[1]), .bus(bus_b.slave));
  turf_tally #(.NUM_PLAYERS(4), .RAM_LATENCY(2), .LAST_ADDR(15'h03FF), .CNT_W(9)) dut_c (
    .clock25(clk), .reset(rst_s[2]), .bus(bus_c.slave));

  assign bus_a.start = start_s[0];
  assign bus_b.start = start_s[1];
  assign bus_c.start = start_s[2];

  // RAM models: a read pipeline of each instance's latency.
  always @(posedge clk) begin
    rp[0][0] <= mem[0][bus_a.ram_address];
    rp[1][0] <= mem[1][bus_b.ram_address];
    rp[2][0] <= mem[2][bus_c.ram_address];
    for (int d = 0; d < 3; d++) begin
      rp[d][1] <= rp[d][0];
      rp[d][2] <= rp[d][1];
    end
  end

  assign bus_a.ram_data = rp[0][0];
  assign bus_b.ram_data = rp[1][2];
  assign bus_c.ram_data = rp[2][1];

  // Colour drive and decode of every instance's outputs into plain ints.
  always_comb begin
    bus_a.player_colours = '0;
    bus_b.player_colours = '0;
    bus_c.player_colours = '0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) begin
        obs_cnt[d][i]  = 0;
        obs_rank[d][i] = 0;
        obs_col[d][i]  = 0;
      end
    for (int i = 0; i < 4; i++) begin
      bus_a.player_colours[i*3 +: 3] = pcol[0][i][2:0];
      bus_c.player_colours[i*3 +: 3] = pcol[2][i][2:0];
      obs_cnt[0][i]  = int'(bus_a.counts[i*15 +: 15]);
      obs_rank[0][i] = int'(bus_a.rank_idx[i*3 +: 3]);
      obs_col[0][i]  = int'(bus_a.ordered_colours[i*3 +: 3]);
      obs_cnt[2][i]  = int'(bus_c.counts[i*9 +: 9]);
      obs_rank[2][i] = int'(bus_c.rank_idx[i*3 +: 3]);
      obs_col[2][i]  = int'(bus_c.ordered_colours[i*3 +: 3]);
    end
    for (int i = 0; i < 6; i++) begin
      bus_b.player_colours[i*3 +: 3] = pcol[1][i][2:0];
      obs_cnt[1][i]  = int'(bus_b.counts[i*15 +: 15]);
      obs_rank[1][i] = int'(bus_b.rank_idx[i*3 +: 3]);
      obs_col[1][i]  = int'(bus_b.ordered_colours[i*3 +: 3]);
    end
    obs_tie[0]  = int'(bus_a.leader_tie);
    obs_tie[1]  = int'(bus_b.leader_tie);
    obs_tie[2]  = int'(bus_c.leader_tie);
    obs_done[0] = int'(bus_a.done_ordering);
    obs_done[1] = int'(bus_b.done_ordering);
    obs_done[2] = int'(bus_c.done_ordering);
    obs_busy[0] = int'(bus_a.busy);
    obs_busy[1] = int'(bus_b.busy);
    obs_busy[2] = int'(bus_c.busy);
    obs_addr[0] = int'(bus_a.ram_address);
    obs_addr[1] = int'(bus_b.ram_address);
    obs_addr[2] = int'(bus_c.ram_address);
  end

  task automatic checkOutput(input string what, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, got, want);
    end
  endtask

  task automatic checkReset(input int d, input string tag);
    for (int i = 0; i < np_of[d]; i++) begin
      checkOutput($sformatf("%s cnt[%0d]", tag, i), obs_cnt[d][i], 0);
      checkOutput($sformatf("%s rank[%0d]", tag, i), obs_rank[d][i], i);
      checkOutput($sformatf("%s col[%0d]", tag, i), obs_col[d][i], 0);
    end
    checkOutput({tag, " tie"}, obs_tie[d], 0);
    checkOutput({tag, " busy"}, obs_busy[d], 0);
    checkOutput({tag, " done"}, obs_done[d], 0);
    checkOutput({tag, " addr"}, obs_addr[d], 0);
  endtask

  task automatic checkRound(input int d, input string tag, input int c[8],
                            input int r[8], input int oc[8], input int tie);
    for (int i = 0; i < np_of[d]; i++) begin
      checkOutput($sformatf("%s cnt[%0d]", tag, i), obs_cnt[d][i], c[i]);
      checkOutput($sformatf("%s rank[%0d]", tag, i), obs_rank[d][i], r[i]);
      checkOutput($sformatf("%s col[%0d]", tag, i), obs_col[d][i], oc[i]);
    end
    checkOutput({tag, " tie"}, obs_tie[d], tie);
    checkOutput({tag, " busy"}, obs_busy[d], 0);
  endtask

  // Reference: count by first matching player with saturation, then rank by
  // repeatedly picking the largest remaining count (lowest index on ties).
  function automatic void refModel(input int d, output int c[8], output int r[8],
                                   output int oc[8], output int tie);
    bit used [8];
    for (int i = 0; i < 8; i++) begin
      c[i] = 0; r[i] = 0; oc[i] = 0; used[i] = 1'b0;
    end
    for (int a = 0; a <= last_of[d]; a++) begin
      int px = int'(mem[d][a]);
      for (int i = 0; i < np_of[d]; i++) begin
        if (pcol[d][i] == px) begin
          if (c[i] < sat_of[d]) c[i]++;
          break;
        end
      end
    end
    for (int s = 0; s < np_of[d]; s++) begin
      int best = -1;
      for (int i = 0; i < np_of[d]; i++)
        if (!used[i] && (best < 0 || c[i] > c[best])) best = i;
      used[best] = 1'b1;
      r[s]  = best;
      oc[s] = pcol[d][best];
    end
    tie = (c[r[0]] == c[r[1]]) ? 1 : 0;
  endfunction

  task automatic fillMem(input int d, input int px[8]);
    int a = 0;
    for (int k = 0; k <= last_of[d]; k++) mem[d][k] = 3'd0;
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < px[v]; k++) begin
        if (a <= last_of[d]) mem[d][a] = 3'(v);
        a++;
      end
  endtask

  // Pulse start, then follow the run edge by edge until done_ordering.
  // restart_at: edge after which a stray start is held for one edge.
  // reset_at:   address at which reset is thrown mid-scan (run aborted).
  // hold_at:    edge at which the previous round's ranking must still show.
  task automatic applyStimulus(input int d, input int restart_at, input int reset_at,
                               input int hold_at, input int hold_rank[8],
                               output int edges, output int aborted);
    string tag = $sformatf("dut%0d", d);
    edges   = 0;
    aborted = 0;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    checkOutput({tag, " busy after start"}, obs_busy[d], 1);
    checkOutput({tag, " done after start"}, obs_done[d], 0);
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (obs_done[d] != 0) break;
      if (edges > last_of[d] + 64) begin
        checkOutput({tag, " done_ordering timeout"}, obs_done[d], 1);
        break;
      end
      if (reset_at >= 0 && obs_addr[d] == reset_at) begin
        rst_s[d] = 1'b1;
        #1;
        checkReset(d, {tag, " mid-scan reset"});
        @(negedge clk);
        rst_s[d] = 1'b0;
        aborted = 1;
        return;
      end
      if (edges == hold_at)
        for (int i = 0; i < np_of[d]; i++)
          checkOutput($sformatf("%s held rank[%0d]", tag, i), obs_rank[d][i], hold_rank[i]);
      start_s[d] = (edges == restart_at);
    end
    start_s[d] = 1'b0;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   c[8], r[8], oc[8], tie;
    int   ea, eb, ab, ab2, sum;
    int   none[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int   prev[8];
    int   seed_px[8] = '{0, 100, 300, 0, 50, 0, 300, 0};

    tbl[0] = '{"all_bg",     '{1,2,4,6}, '{0,0,0,0,0,0,0,0},
               '{0,0,0,0}, '{0,1,2,3}, '{1,2,4,6}, 1};
    tbl[1] = '{"seeded",     '{1,2,4,6}, '{0,100,300,0,50,0,300,0},
               '{100,300,50,300}, '{1,3,0,2}, '{2,6,1,4}, 1};
    tbl[2] = '{"saturate",   '{1,2,4,6}, '{0,1024,0,0,0,0,0,0},
               '{511,0,0,0}, '{0,1,2,3}, '{1,2,4,6}, 0};
    tbl[3] = '{"dup_colour", '{3,5,3,7}, '{0,0,0,200,0,250,77,201},
               '{200,250,0,201}, '{1,3,0,2}, '{5,7,3,3}, 0};
    tbl[4] = '{"bg_player",  '{0,1,2,3}, '{0,10,12,5,0,0,0,0},
               '{511,10,12,5}, '{0,2,1,3}, '{0,2,1,3}, 0};
    tbl[5] = '{"sat_tie",    '{1,2,4,6}, '{0,0,512,0,0,0,511,0},
               '{0,511,0,511}, '{1,3,0,2}, '{2,6,1,4}, 1};

    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      rst_s[d]   = 1'b1;
      for (int i = 0; i < 8; i++) pcol[d][i] = 0;
    end
    pcol[0][0] = 1; pcol[0][1] = 2; pcol[0][2] = 4; pcol[0][3] = 6;
    pcol[1][0] = 1; pcol[1][1] = 2; pcol[1][2] = 4; pcol[1][3] = 6;
    pcol[1][4] = 3; pcol[1][5] = 5;
    pcol[2][0] = 1; pcol[2][1] = 2; pcol[2][2] = 4; pcol[2][3] = 6;

    repeat (3) @(posedge clk);
    #1;
    checkReset(0, "A reset");
    checkReset(1, "B reset");
    checkReset(2, "C reset");
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;

    // Whole field painted in player-slot-2 colour, A and B side by side.
    for (int a = 0; a < 20352; a++) begin
      mem[0][a] = 3'd4;
      mem[1][a] = 3'd4;
    end
    fork
      applyStimulus(0, -1, -1, -1, none, ea, ab);
      applyStimulus(1, -1, -1, -1, none, eb, ab2);
    join
    checkOutput("A fill latency", ea, 20357);
    checkOutput("B fill latency", eb, 20361);
    c  = '{0, 0, 20352, 0, 0, 0, 0, 0};
    r  = '{2, 0, 1, 3, 0, 0, 0, 0};
    oc = '{4, 1, 2, 6, 0, 0, 0, 0};
    checkRound(0, "A fill", c, r, oc, 0);
    sum = 0;
    for (int i = 0; i < 6; i++) sum += obs_cnt[1][i];
    checkOutput("B fill count sum", sum, 20352);
    refModel(1, c, r, oc, tie);
    checkRound(1, "B fill", c, r, oc, tie);

    // Reset at address 0x2000, then a clean rerun with a stray start at 500.
    fillMem(0, seed_px);
    applyStimulus(0, -1, 'h2000, -1, none, ea, ab);
    checkOutput("A reset aborted run", ab, 1);
    applyStimulus(0, 500, -1, 600, none, ea, ab);
    checkOutput("A restart latency", ea, 20357);
    c  = '{100, 300, 50, 300, 0, 0, 0, 0};
    r  = '{1, 3, 0, 2, 0, 0, 0, 0};
    oc = '{2, 6, 1, 4, 0, 0, 0, 0};
    checkRound(0, "A seeded", c, r, oc, 1);

    // start and reset together: reset must win.
    @(negedge clk);
    start_s[2] = 1'b1;
    rst_s[2]   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("C start+reset busy", obs_busy[2], 0);
    @(negedge clk);
    start_s[2] = 1'b0;
    rst_s[2]   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("C start+reset stays idle", obs_busy[2], 0);

    // Table of small-field cases on instance C.
    prev = '{0, 1, 2, 3, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) pcol[2][i] = tbl[k].colours[i];
      fillMem(2, tbl[k].px);
      applyStimulus(2, -1, -1, 200, prev, ea, ab);
      checkOutput({"C ", tbl[k].name, " latency"}, ea, 1030);
      for (int i = 0; i < 8; i++) begin
        c[i]  = (i < 4) ? tbl[k].exp_cnt[i]  : 0;
        r[i]  = (i < 4) ? tbl[k].exp_rank[i] : 0;
        oc[i] = (i < 4) ? tbl[k].exp_col[i]  : 0;
      end
      checkRound(2, {"C ", tbl[k].name}, c, r, oc, tbl[k].exp_tie);
      prev = r;
    end

    // Randomised fields and colours against the reference model.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) pcol[2][i] = int'($urandom_range(0, 7));
      for (int a = 0; a <= last_of[2]; a++)
        mem[2][a] = (k == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      refModel(2, c, r, oc, tie);
      applyStimulus(2, (k == 1) ? 300 : -1, -1, 100, prev, ea, ab);
      checkOutput($sformatf("C random%0d latency", k), ea, 1030);
      checkRound(2, $sformatf("C random%0d", k), c, r, oc, tie);
      prev = r;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
